// File: rtl/mips_pkg.sv
// Shared constants and elaboration helpers for the MIPS pipeline core.
// Imported by the ID-stage hazard logic and its support blocks.
package mips_pkg;

    localparam int REG_ZERO        = 0;
    localparam int RADDR_W_DEFAULT = 5;
    localparam int LOAD_LAT_MAX    = 15;

    // Ceiling log2 with a floor of 1 so that a 1-bit field is never zero width.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/load_use_scoreboard_sat_counter.sv
// Saturating event counter with a synchronous clear.
// Used for the hazard unit's stall statistics.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic at_max;

    assign at_max = (count == {CNT_W{1'b1}});

    // Clear wins over increment so software can zero the counter mid-stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use hazard scoreboard for the ID stage: per-register countdowns of
// in-flight loads, a combinational stall, and saturating stall statistics.
module load_use_scoreboard
    import mips_pkg::*;
#(
    parameter int RADDR_W  = RADDR_W_DEFAULT,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic                     issue_is_load,
    input  logic                     issue_writes,
    input  logic [RADDR_W-1:0]       issue_dest,
    input  logic [RADDR_W-1:0]       src_a,
    input  logic                     src_a_used,
    input  logic [RADDR_W-1:0]       src_b,
    input  logic                     src_b_used,
    input  logic                     flush,
    input  logic                     clr_stats,
    output logic                     stall,
    output logic [(2**RADDR_W)-1:0]  busy_vec,
    output logic [CNT_W-1:0]         stall_cycles,
    output logic [CNT_W-1:0]         stall_events
);

    localparam int NREG = 2**RADDR_W;
    localparam int CW   = clog2(LOAD_LAT + 1);

    logic live;
    logic hazard_a;
    logic hazard_b;
    logic accept;
    logic dest_nonzero;
    logic write_en;
    logic load_en;
    logic alu_en;
    logic stall_q;
    logic stall_rise;

    // A flushed slot is dead: it neither stalls nor touches the scoreboard.
    assign live     = issue_valid & ~flush;
    assign hazard_a = src_a_used & busy_vec[src_a];
    assign hazard_b = src_b_used & busy_vec[src_b];
    assign stall    = live & (hazard_a | hazard_b);
    assign accept   = live & ~stall;

    assign dest_nonzero = (issue_dest != RADDR_W'(REG_ZERO));
    assign write_en     = accept & issue_writes & dest_nonzero;
    assign load_en      = write_en & issue_is_load;
    assign alu_en       = write_en & ~issue_is_load;

    assign busy_vec[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic [CW-1:0] cnt;
        logic          hit;

        assign hit = (issue_dest == RADDR_W'(r));

        // A new load restarts the countdown; a younger ALU write to the same
        // register is forwarded through EX/MEM, so the pending load no longer matters.
        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt <= '0;
            end else if (load_en && hit) begin
                cnt <= CW'(LOAD_LAT);
            end else if (alu_en && hit) begin
                cnt <= '0;
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end

        assign busy_vec[r] = (cnt != '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall;
        end
    end

    assign stall_rise = stall & ~stall_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cycles (
        .clk   (clk),
        .reset (reset),
        .inc   (stall),
        .clr   (clr_stats),
        .count (stall_cycles)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_events (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_rise),
        .clr   (clr_stats),
        .count (stall_events)
    );

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed bench for load_use_scoreboard: three instances (LOAD_LAT 1, 3 and
// 15 with 4-bit stats) share one stimulus stream; each phase checks one of them.
module tb_load_use_scoreboard;

    logic       clk;
    logic       reset;
    logic       issue_valid;
    logic       issue_is_load;
    logic       issue_writes;
    logic [4:0] issue_dest;
    logic [4:0] src_a;
    logic       src_a_used;
    logic [4:0] src_b;
    logic       src_b_used;
    logic       flush;
    logic       clr_stats;

    logic        stall1, stall3, stall15;
    logic [31:0] busy1, busy3, busy15;
    logic [31:0] cyc1, cyc3;
    logic [31:0] evt1, evt3;
    logic [3:0]  cyc15, evt15;

    int tests;
    int fails;

    load_use_scoreboard #(.RADDR_W(5), .LOAD_LAT(1), .CNT_W(32)) u1 (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_is_load(issue_is_load),
        .issue_writes(issue_writes), .issue_dest(issue_dest), .src_a(src_a), .src_a_used(src_a_used),
        .src_b(src_b), .src_b_used(src_b_used), .flush(flush), .clr_stats(clr_stats),
        .stall(stall1), .busy_vec(busy1), .stall_cycles(cyc1), .stall_events(evt1));

    load_use_scoreboard #(.RADDR_W(5), .LOAD_LAT(3), .CNT_W(32)) u3 (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_is_load(issue_is_load),
        .issue_writes(issue_writes), .issue_dest(issue_dest), .src_a(src_a), .src_a_used(src_a_used),
        .src_b(src_b), .src_b_used(src_b_used), .flush(flush), .clr_stats(clr_stats),
        .stall(stall3), .busy_vec(busy3), .stall_cycles(cyc3), .stall_events(evt3));

    load_use_scoreboard #(.RADDR_W(5), .LOAD_LAT(15), .CNT_W(4)) u15 (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_is_load(issue_is_load),
        .issue_writes(issue_writes), .issue_dest(issue_dest), .src_a(src_a), .src_a_used(src_a_used),
        .src_b(src_b), .src_b_used(src_b_used), .flush(flush), .clr_stats(clr_stats),
        .stall(stall15), .busy_vec(busy15), .stall_cycles(cyc15), .stall_events(evt15));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_idle();
        issue_valid = 1'b0; issue_is_load = 1'b0; issue_writes = 1'b0; issue_dest = 5'd0;
        src_a = 5'd0; src_a_used = 1'b0; src_b = 5'd0; src_b_used = 1'b0;
    endtask

    // Load with base register $0, so the load itself never waits.
    task automatic set_lw(input logic [4:0] d);
        issue_valid = 1'b1; issue_is_load = 1'b1; issue_writes = 1'b1; issue_dest = d;
        src_a = 5'd0; src_a_used = 1'b1; src_b = 5'd0; src_b_used = 1'b0;
    endtask

    task automatic set_alu(input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        issue_valid = 1'b1; issue_is_load = 1'b0; issue_writes = 1'b1; issue_dest = d;
        src_a = a; src_a_used = 1'b1; src_b = b; src_b_used = 1'b1;
    endtask

    task automatic do_reset();
        set_idle();
        flush = 1'b0; clr_stats = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Reset state
        do_reset();
        settle();
        chk("rst_stall", {31'd0, stall1}, 32'd0);
        chk("rst_busy", busy1, 32'd0);
        chk("rst_cycles", cyc1, 32'd0);
        chk("rst_events", evt1, 32'd0);
        chk("rst_cycles15", {28'd0, cyc15}, 32'd0);

        // Single load-use, LOAD_LAT=1
        set_lw(5'd1); settle();
        chk("t1_lw_stall", {31'd0, stall1}, 32'd0);
        tick();
        set_alu(5'd3, 5'd1, 5'd1); settle();
        chk("t1_add_stall", {31'd0, stall1}, 32'd1);
        chk("t1_busy", busy1, 32'h2);
        tick();
        settle();
        chk("t1_add_accept", {31'd0, stall1}, 32'd0);
        chk("t1_cycles", cyc1, 32'd1);
        chk("t1_events", evt1, 32'd1);
        tick();
        set_idle(); settle();
        chk("t1_busy_end", busy1, 32'd0);
        chk("t1_cycles_end", cyc1, 32'd1);

        // Double load-use, LOAD_LAT=1
        do_reset();
        set_lw(5'd1); tick();
        set_lw(5'd2); settle();
        chk("t2_lw2_stall", {31'd0, stall1}, 32'd0);
        tick();
        set_alu(5'd3, 5'd1, 5'd2); settle();
        chk("t2_add_stall", {31'd0, stall1}, 32'd1);
        chk("t2_busy", busy1, 32'h4);
        tick();
        settle();
        chk("t2_add_accept", {31'd0, stall1}, 32'd0);
        chk("t2_events", evt1, 32'd1);
        chk("t2_cycles", cyc1, 32'd1);
        tick();

        // LOAD_LAT=3: with one filler the consumer waits 2 cycles, without it 3
        do_reset();
        set_lw(5'd5); tick();
        set_alu(5'd6, 5'd7, 5'd8); settle();
        chk("t3_filler_stall", {31'd0, stall3}, 32'd0);
        tick();
        set_alu(5'd9, 5'd5, 5'd5);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("t3_sub_stall", {31'd0, stall3}, 32'd1);
            tick();
        end
        settle();
        chk("t3_sub_accept", {31'd0, stall3}, 32'd0);
        chk("t3_cycles_a", cyc3, 32'd2);
        tick();
        set_lw(5'd5); tick();
        set_alu(5'd9, 5'd5, 5'd5);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t3_nofill_stall", {31'd0, stall3}, 32'd1);
            tick();
        end
        settle();
        chk("t3_nofill_accept", {31'd0, stall3}, 32'd0);
        chk("t3_cycles_b", cyc3, 32'd5);
        chk("t3_events", evt3, 32'd2);
        tick();

        // $0 is never busy; a younger ALU write cancels a pending load (LOAD_LAT=3)
        do_reset();
        set_lw(5'd0); tick();
        set_alu(5'd3, 5'd0, 5'd0); settle();
        chk("t4_r0_busy", busy3, 32'd0);
        chk("t4_r0_stall", {31'd0, stall3}, 32'd0);
        tick();
        set_lw(5'd4); tick();
        set_alu(5'd4, 5'd0, 5'd0); settle();
        chk("t4_addi_stall", {31'd0, stall3}, 32'd0);
        chk("t4_busy_pre", busy3, 32'h10);
        tick();
        set_alu(5'd7, 5'd4, 5'd4); settle();
        chk("t4_waw_busy", busy3, 32'd0);
        chk("t4_waw_stall", {31'd0, stall3}, 32'd0);
        tick();

        // Flush drops the stall but the countdown keeps running
        do_reset();
        set_lw(5'd5); tick();
        set_alu(5'd9, 5'd5, 5'd0); settle();
        chk("t5_pre_stall", {31'd0, stall3}, 32'd1);
        tick();
        flush = 1'b1; settle();
        chk("t5_flush_stall", {31'd0, stall3}, 32'd0);
        tick();
        flush = 1'b0; settle();
        chk("t5_post_stall", {31'd0, stall3}, 32'd1);
        chk("t5_post_busy", busy3, 32'h20);
        tick();
        settle();
        chk("t5_accept", {31'd0, stall3}, 32'd0);
        chk("t5_cycles", cyc3, 32'd2);
        chk("t5_events", evt3, 32'd2);
        tick();
        set_lw(5'd6); flush = 1'b1; tick();
        flush = 1'b0; set_idle(); settle();
        chk("t5_flushed_lw", busy3, 32'd0);

        // Reset in the middle of a countdown
        set_lw(5'd5); tick();
        set_idle(); settle();
        chk("t6_busy_pre", busy3, 32'h20);
        reset = 1'b0; tick();
        reset = 1'b1; settle();
        chk("t6_busy_rst", busy3, 32'd0);
        chk("t6_cycles_rst", cyc3, 32'd0);
        chk("t6_events_rst", evt3, 32'd0);

        // Stats saturation with 4-bit counters, LOAD_LAT=15
        do_reset();
        set_lw(5'd1); tick();
        set_alu(5'd3, 5'd1, 5'd0);
        for (int i = 0; i < 15; i++) begin
            settle();
            chk("t7_stall", {31'd0, stall15}, 32'd1);
            tick();
        end
        settle();
        chk("t7_accept", {31'd0, stall15}, 32'd0);
        chk("t7_cycles_full", {28'd0, cyc15}, 32'd15);
        tick();
        set_lw(5'd1); tick();
        set_alu(5'd3, 5'd1, 5'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        settle();
        chk("t7_stall2", {31'd0, stall15}, 32'd1);
        chk("t7_cycles_sat", {28'd0, cyc15}, 32'd15);
        chk("t7_events", {28'd0, evt15}, 32'd2);
        clr_stats = 1'b1; tick();
        clr_stats = 1'b0; settle();
        chk("t7_clr_cycles", {28'd0, cyc15}, 32'd0);
        chk("t7_clr_events", {28'd0, evt15}, 32'd0);
        chk("t7_busy", busy15, 32'h2);
        tick();
        settle();
        chk("t7_cycles_after", {28'd0, cyc15}, 32'd1);
        chk("t7_events_after", {28'd0, evt15}, 32'd0);

        set_idle();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_use_scoreboard.md
Name: load_use_scoreboard

Overview:
- Parametrised load-use hazard unit for the MIPS pipeline core. It replaces the fixed one-bubble load-use detector.
- Tracks in-flight loads per architectural register with countdown timers and stalls the ID stage until each source operand is forwardable.
- Supports a configurable memory latency so the core can use multi-cycle data memories.
- Includes saturating stall performance counters.
- Sits beside the ID stage. Its stall output drives the PC/IF-ID hold and the ID/EX bubble insert.

Parameters:
- RADDR_W, 5: register address width. NREG = 2**RADDR_W is a derived localparam.
- LOAD_LAT, 1: stall cycles a dependent instruction needs directly after a load. Legal range 1..15; 1 gives the classic single bubble.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- issue_valid  in  1  ID instruction is valid this cycle.
- issue_is_load  in  1  ID instruction is a load.
- issue_writes  in  1  ID instruction writes a destination register.
- issue_dest  in  RADDR_W  destination register.
- src_a  in  RADDR_W  rs.
- src_a_used  in  1  rs is read.
- src_b  in  RADDR_W  rt.
- src_b_used  in  1  rt is read.
- flush  in  1  squash the ID instruction (branch/jump redirect).
- clr_stats  in  1  zero the performance counters.
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- busy_vec  out  NREG  bit r set when register r has a pending load countdown.
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1.
- stall_events  out  CNT_W  saturating count of stall episodes (0->1 transitions of stall).

Behaviour:
- State:
  - cnt[r] for r = 1..NREG-1. Width CW = clog2(LOAD_LAT+1).
  - cnt[0] is constant 0, so register $0 is never busy.
  - stall_q: registered copy of stall, used for edge detection.
- Reset (reset==0 at a clk edge):
  - All cnt, stall_q and both counters are cleared.
  - Outputs are then stall=0, busy_vec=0, stall_cycles=0, stall_events=0.
  - Reset applied mid-countdown discards every pending hazard.
- busy[r] = (cnt[r] != 0). busy_vec is driven directly from the registers.
- stall is combinational: issue_valid & ~flush & ((src_a_used & busy[src_a]) | (src_b_used & busy[src_b])).
- "accept" = issue_valid & ~flush & ~stall.
- Per-cycle counter update, in priority order:
  1. accept & issue_writes & issue_is_load & issue_dest!=0 → cnt[issue_dest] <= LOAD_LAT. A new load wins over the decrement of the same register.
  2. accept & issue_writes & ~issue_is_load & issue_dest!=0 → cnt[issue_dest] <= 0. This is a WAW override: the younger ALU result is forwarded through the normal EX/MEM path.
  3. Every other register with cnt != 0 decrements by 1.
- Timing:
  - A load accepted in cycle t makes a consumer in cycle t+1 stall for exactly LOAD_LAT cycles, t+1..t+LOAD_LAT.
  - The consumer is accepted in cycle t+LOAD_LAT+1.
  - A consumer arriving k cycles after the load stalls max(0, LOAD_LAT+1-k) cycles.
- Both sources busy: stall persists until both counters reach 0, i.e. the stall length is the maximum of the two.
- A stalled instruction does not update the scoreboard. Its load/dest fields are only acted on in the accept cycle.
- flush: forces stall=0 and suppresses the scoreboard update for that cycle. Pending counters still decrement, because older in-flight loads continue.
- Stats:
  - stall_cycles increments when stall=1 and saturates at all-ones.
  - stall_events increments on stall & ~stall_q and saturates.
  - clr_stats zeroes both counters and has priority over increment in the same cycle.
- The block has no effect on forwarding muxes. It only guarantees that operands are forwardable when the instruction is accepted.

Decomposition:
- Shared package mips_pkg holds:
  - REG_ZERO = 0.
  - The RADDR_W default.
  - The max-legal LOAD_LAT constant.
  - The clog2 helper function.
- One natural sub-module, sat_counter (CNT_W, inc, clr), instantiated twice for the stats.
- The scoreboard array stays inline, in a generate loop over r = 1..NREG-1.

Test Plan:
- Single load-use, LOAD_LAT=1: lw $1 in cycle t, then add $3,$1,$1 → stall=1 for exactly 1 cycle; add accepted at t+2; stall_cycles=1, stall_events=1.
- Double load-use, LOAD_LAT=1: lw $1, lw $2, then add $3,$1,$2 in consecutive cycles → first lw causes no stall; add stalls 1 cycle (on $2 only); busy_vec=0x4 during the stall; stall_events=1.
- LOAD_LAT=3: lw $5, then independent or, then sub using $5 → sub stalls 2 cycles; with no filler instruction it stalls 3 cycles.
- $0 and WAW:
  - lw $0 followed by a consumer of $0 → no stall, busy_vec stays 0.
  - lw $4 then addi $4, then a consumer of $4 → no stall (cnt[4] cleared by the addi).
- Flush and reset:
  - flush asserted while a consumer is stalled → stall drops to 0 that cycle; countdown continues.
  - reset=0 mid-countdown → busy_vec=0, counters=0 next cycle.
- Stats saturation (CNT_W=4): hold a dependent instruction stalled under LOAD_LAT=15 for 20 cycles → stall_cycles stays at 15; clr_stats together with stall=1 → stall_cycles=0 the next cycle.
